sad_pe_row: RTL and testbench



---
 rtl/me_pkg.sv | 27 ++
 rtl/sad_pe_row_if.sv | 32 +++
 rtl/sad_pe.sv | 87 ++++++++
 rtl/sad_pe_row.sv | 63 ++++++
 tb/tb_sad_pe_row.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation SAD datapath.
package me_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ACC_W  = 16;

  // Control tuple that travels down the row alongside the reference pixel.
  typedef struct packed {
    logic valid;
    logic new_dist;
    logic last_pix;
  } pe_tag_t;

  // Unsigned add clamped to (2^width - 1). Works on up to 32-bit operands.
  // Returns {clamped, value}; only the low `width` bits of value are significant.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    if (sum > lim) sat_add = {1'b1, lim[31:0]};
    else           sat_add = {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/sad_pe_row_if.sv
// Beat and result bundle for a row of SAD processing elements.
// Handshake: in_valid qualifies r_in, new_dist and last_pix on the cycle it is
// high; there is no backpressure, the row accepts a beat every cycle. The
// results side has no ready either: dist_valid is a one-cycle strobe that the
// consumer must take when it appears.
interface sad_pe_row_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int NUM_PE = 4
);
  logic [DATA_W-1:0]       r_in;
  logic [DATA_W-1:0]       s1;
  logic [DATA_W-1:0]       s2;
  logic [NUM_PE-1:0]       s2_sel;
  logic                    in_valid;
  logic                    new_dist;
  logic                    last_pix;
  logic [NUM_PE*ACC_W-1:0] acc;
  logic [NUM_PE-1:0]       dist_valid;
  logic [NUM_PE-1:0]       sat;
  logic [DATA_W-1:0]       r_out;

  modport master (
    output r_in, s1, s2, s2_sel, in_valid, new_dist, last_pix,
    input  acc, dist_valid, sat, r_out
  );

  modport slave (
    input  r_in, s1, s2, s2_sel, in_valid, new_dist, last_pix,
    output acc, dist_valid, sat, r_out
  );
endinterface

// File: rtl/sad_pe.sv
// One SAD lane: absolute difference stage, saturating accumulate stage, and
// the chain register that forwards R and its tags to the next lane.
module sad_pe
  import me_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W   // DATA_W <= ACC_W <= 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] r_in,
  input  pe_tag_t           tag_in,
  input  logic [DATA_W-1:0] s1,
  input  logic [DATA_W-1:0] s2,
  input  logic              s2_sel,
  output logic [DATA_W-1:0] r_chain,
  output pe_tag_t           tag_chain,
  output logic [ACC_W-1:0]  acc,
  output logic              dist_valid,
  output logic              sat
);

  logic [DATA_W-1:0] s_pick;
  logic [DATA_W-1:0] ad_d;
  logic [DATA_W-1:0] ad_q;
  pe_tag_t           tag_q;
  logic              open_q;   // a new_dist has been seen and its last_pix has not
  logic [32:0]       sum_w;
  logic              clamp;
  logic              unused_sum;

  // Absolute difference of the lane's R against the selected broadcast S.
  always_comb begin
    s_pick = s2_sel ? s2 : s1;
    ad_d   = (r_in >= s_pick) ? (r_in - s_pick) : (s_pick - r_in);
  end

  assign sum_w      = sat_add(32'(acc), 32'(ad_q), ACC_W);
  assign clamp      = sum_w[32];
  assign unused_sum = ^sum_w;

  // Stage 1: capture ad on valid beats; invalid beats become tag-free bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ad_q  <= '0;
      tag_q <= '0;
    end else begin
      tag_q <= tag_in.valid ? tag_in : '0;
      if (tag_in.valid) ad_q <= ad_d;
    end
  end

  // Stage 2: restart or saturating-accumulate; strobe only for a distance
  // whose new_dist was actually seen, so a reset mid-distance yields no strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      sat        <= 1'b0;
      dist_valid <= 1'b0;
      open_q     <= 1'b0;
    end else begin
      dist_valid <= tag_q.valid & tag_q.last_pix & (tag_q.new_dist | open_q);
      if (tag_q.valid) begin
        if (tag_q.new_dist) begin
          acc <= ACC_W'(ad_q);
          sat <= 1'b0;
        end else begin
          acc <= sum_w[ACC_W-1:0];
          if (clamp) sat <= 1'b1;
        end
        open_q <= (tag_q.new_dist | open_q) & ~tag_q.last_pix;
      end
    end
  end

  // Chain register: forward R and the raw tuple one lane down every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chain   <= '0;
      tag_chain <= '0;
    end else begin
      r_chain   <= r_in;
      tag_chain <= tag_in;
    end
  end

endmodule

// File: rtl/sad_pe_row.sv
// Row of NUM_PE SAD lanes. R and its tags ripple one lane per cycle; S1/S2
// are broadcast undelayed, so lane i compares R from i cycles ago with
// today's search pixels.
module sad_pe_row
  import me_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int NUM_PE = 4
) (
  input logic          clock,
  input logic          reset_n,
  sad_pe_row_if.slave  bus
);

  logic [DATA_W-1:0] r_ch   [NUM_PE];
  pe_tag_t           tag_ch [NUM_PE];
  pe_tag_t           tag_head;
  logic              unused_tail;

  assign tag_head    = {bus.in_valid, bus.new_dist, bus.last_pix};
  assign bus.r_out   = r_ch[NUM_PE-1];
  assign unused_tail = ^tag_ch[NUM_PE-1];

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    logic [DATA_W-1:0] r_lane;
    pe_tag_t           tag_lane;
    logic [ACC_W-1:0]  acc_l;
    logic              dv_l;
    logic              sat_l;

    if (i == 0) begin : g_head
      assign r_lane   = bus.r_in;
      assign tag_lane = tag_head;
    end else begin : g_body
      assign r_lane   = r_ch[i-1];
      assign tag_lane = tag_ch[i-1];
    end

    sad_pe #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_pe (
      .clock      (clock),
      .reset_n    (reset_n),
      .r_in       (r_lane),
      .tag_in     (tag_lane),
      .s1         (bus.s1),
      .s2         (bus.s2),
      .s2_sel     (bus.s2_sel[i]),
      .r_chain    (r_ch[i]),
      .tag_chain  (tag_ch[i]),
      .acc        (acc_l),
      .dist_valid (dv_l),
      .sat        (sat_l)
    );

    assign bus.acc[i*ACC_W +: ACC_W] = acc_l;
    assign bus.dist_valid[i]         = dv_l;
    assign bus.sat[i]                = sat_l;
  end

endmodule

// File: tb/tb_sad_pe_row.sv
// Directed bench for sad_pe_row: a default 4-lane row plus a 1-lane row with
// a 10-bit accumulator, both fed the same beats.
module tb_sad_pe_row;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  sad_pe_row_if #(.DATA_W(8), .ACC_W(16), .NUM_PE(4)) if_a ();
  sad_pe_row_if #(.DATA_W(8), .ACC_W(10), .NUM_PE(1)) if_b ();

  sad_pe_row #(.DATA_W(8), .ACC_W(16), .NUM_PE(4)) u_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  sad_pe_row #(.DATA_W(8), .ACC_W(10), .NUM_PE(1)) u_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic [7:0] r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic v, input logic nd, input logic lp);
    if_a.r_in = r;  if_a.s1 = a;  if_a.s2 = b;  if_a.s2_sel = sel;
    if_a.in_valid = v;  if_a.new_dist = nd;  if_a.last_pix = lp;
    if_b.r_in = r;  if_b.s1 = a;  if_b.s2 = b;  if_b.s2_sel = sel[0];
    if_b.in_valid = v;  if_b.new_dist = nd;  if_b.last_pix = lp;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    drive(8'd0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_vec++; if (if_a.acc !== 64'd0) begin n_err++; $display("FAIL reset_acc: got %h expected 0", if_a.acc); end
    n_vec++; if (if_a.dist_valid !== 4'd0) begin n_err++; $display("FAIL reset_dv: got %b expected 0", if_a.dist_valid); end
    n_vec++; if (if_a.sat !== 4'd0) begin n_err++; $display("FAIL reset_sat: got %b expected 0", if_a.sat); end
    n_vec++; if (if_a.r_out !== 8'd0) begin n_err++; $display("FAIL reset_rout: got %0d expected 0", if_a.r_out); end
    n_vec++; if (if_b.acc !== 10'd0) begin n_err++; $display("FAIL reset_acc_b: got %0d expected 0", if_b.acc); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    drive(8'd3, 8'd0, 8'd5, 4'b0001, 1'b1, 1'b1, 1'b0); tick();
    drive(8'd3, 8'd0, 8'd5, 4'b0001, 1'b1, 1'b0, 1'b0); tick();
    drive(8'd3, 8'd0, 8'd5, 4'b0001, 1'b1, 1'b0, 1'b1); tick();
    n_vec++; if (if_a.dist_valid[0] !== 1'b0) begin n_err++; $display("FAIL basic_dv_early: got %b expected 0", if_a.dist_valid[0]); end
    idle(1);
    n_vec++; if (if_a.dist_valid[0] !== 1'b1) begin n_err++; $display("FAIL basic_dv: got %b expected 1", if_a.dist_valid[0]); end
    n_vec++; if (if_a.acc[15:0] !== 16'd6) begin n_err++; $display("FAIL basic_acc: got %0d expected 6", if_a.acc[15:0]); end
    n_vec++; if (if_a.sat[0] !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b expected 0", if_a.sat[0]); end
    idle(1);
    n_vec++; if (if_a.dist_valid[0] !== 1'b0) begin n_err++; $display("FAIL basic_dv_pulse: got %b expected 0", if_a.dist_valid[0]); end
    n_vec++; if (if_a.acc[15:0] !== 16'd6) begin n_err++; $display("FAIL basic_acc_hold: got %0d expected 6", if_a.acc[15:0]); end
    idle(6);
  endtask

  task automatic test_large();
    logic [3:0] exp_dv;
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
    for (int n = 1; n <= 7; n++) begin
      exp_dv = (n >= 2 && n <= 5) ? 4'(1 << (n - 2)) : 4'd0;
      n_vec++; if (if_a.dist_valid !== exp_dv) begin n_err++; $display("FAIL large_dv n=%0d: got %b expected %b", n, if_a.dist_valid, exp_dv); end
      idle(1);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (if_a.acc[i*16 +: 16] !== 16'd750) begin n_err++; $display("FAIL large_acc lane %0d: got %0d expected 750", i, if_a.acc[i*16 +: 16]); end
    end
    idle(4);
  endtask

  task automatic test_saturation();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(8'd250, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
    n_vec++; if (if_b.acc !== 10'd1000) begin n_err++; $display("FAIL sat_pre_acc: got %0d expected 1000", if_b.acc); end
    n_vec++; if (if_b.sat !== 1'b0) begin n_err++; $display("FAIL sat_pre_flag: got %b expected 0", if_b.sat); end
    idle(1);
    n_vec++; if (if_b.acc !== 10'd1023) begin n_err++; $display("FAIL sat_acc: got %0d expected 1023", if_b.acc); end
    n_vec++; if (if_b.sat !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b expected 1", if_b.sat); end
    n_vec++; if (if_b.dist_valid !== 1'b1) begin n_err++; $display("FAIL sat_dv: got %b expected 1", if_b.dist_valid); end
    n_vec++; if (if_a.acc[15:0] !== 16'd1250) begin n_err++; $display("FAIL sat_wide_acc: got %0d expected 1250", if_a.acc[15:0]); end
    n_vec++; if (if_a.sat[0] !== 1'b0) begin n_err++; $display("FAIL sat_wide_flag: got %b expected 0", if_a.sat[0]); end
    idle(2);
    n_vec++; if (if_b.sat !== 1'b1) begin n_err++; $display("FAIL sat_sticky: got %b expected 1", if_b.sat); end
    drive(8'd9, 8'd9, 8'd0, 4'd0, 1'b1, 1'b1, 1'b1); tick();
    idle(1);
    n_vec++; if (if_b.acc !== 10'd0) begin n_err++; $display("FAIL sat_clear_acc: got %0d expected 0", if_b.acc); end
    n_vec++; if (if_b.sat !== 1'b0) begin n_err++; $display("FAIL sat_clear_flag: got %b expected 0", if_b.sat); end
    n_vec++; if (if_b.dist_valid !== 1'b1) begin n_err++; $display("FAIL sat_clear_dv: got %b expected 1", if_b.dist_valid); end
    idle(6);
  endtask

  task automatic test_skew();
    logic [3:0] exp_dv;
    logic [7:0] exp_r;
    for (int t = 0; t < 10; t++) begin
      if (t < 4) drive(8'(10 * (t + 1)), 8'(t + 1), 8'd0, 4'd0, 1'b1, t == 0, t == 3);
      else       drive(8'd0, 8'(t + 1), 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (t + 1 >= 3 && t + 1 <= 7) begin
        exp_r = (t + 1 >= 4) ? 8'(10 * (t - 2)) : 8'd0;
        n_vec++; if (if_a.r_out !== exp_r) begin n_err++; $display("FAIL skew_rout n=%0d: got %0d expected %0d", t + 1, if_a.r_out, exp_r); end
      end
      if (t + 1 == 2) begin
        n_vec++; if (if_a.acc[15:0] !== 16'd9) begin n_err++; $display("FAIL skew_first_ad0: got %0d expected 9", if_a.acc[15:0]); end
      end
      if (t + 1 == 3) begin
        n_vec++; if (if_a.acc[31:16] !== 16'd8) begin n_err++; $display("FAIL skew_first_ad1: got %0d expected 8", if_a.acc[31:16]); end
      end
      exp_dv = (t + 1 >= 5 && t + 1 <= 8) ? 4'(1 << (t - 4)) : 4'd0;
      n_vec++; if (if_a.dist_valid !== exp_dv) begin n_err++; $display("FAIL skew_dv n=%0d: got %b expected %b", t + 1, if_a.dist_valid, exp_dv); end
    end
    n_vec++; if (if_a.acc[15:0]  !== 16'd90) begin n_err++; $display("FAIL skew_acc0: got %0d expected 90", if_a.acc[15:0]); end
    n_vec++; if (if_a.acc[31:16] !== 16'd86) begin n_err++; $display("FAIL skew_acc1: got %0d expected 86", if_a.acc[31:16]); end
    n_vec++; if (if_a.acc[47:32] !== 16'd82) begin n_err++; $display("FAIL skew_acc2: got %0d expected 82", if_a.acc[47:32]); end
    n_vec++; if (if_a.acc[63:48] !== 16'd78) begin n_err++; $display("FAIL skew_acc3: got %0d expected 78", if_a.acc[63:48]); end
    idle(6);
  endtask

  task automatic test_bubbles();
    logic [3:0] exp_dv;
    drive(8'd7, 8'd2, 8'd0, 4'd0, 1'b1, 1'b1, 1'b1); tick();
    n_vec++; if (if_a.dist_valid !== 4'd0) begin n_err++; $display("FAIL bub_dv_early: got %b expected 0", if_a.dist_valid); end
    for (int n = 2; n <= 5; n++) begin
      // invalid beats carrying both tags must be ignored
      drive(8'd99, 8'd2, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1); tick();
      exp_dv = 4'(1 << (n - 2));
      n_vec++; if (if_a.acc[15:0] !== 16'd5) begin n_err++; $display("FAIL bub_acc n=%0d: got %0d expected 5", n, if_a.acc[15:0]); end
      n_vec++; if (if_a.dist_valid !== exp_dv) begin n_err++; $display("FAIL bub_dv n=%0d: got %b expected %b", n, if_a.dist_valid, exp_dv); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(8'd99, 8'd2, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1); tick();
      n_vec++; if (if_a.dist_valid !== 4'd0) begin n_err++; $display("FAIL bub_dv_quiet k=%0d: got %b expected 0", k, if_a.dist_valid); end
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    drive(8'd1, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
    drive(8'd2, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    n_vec++; if (if_a.acc[15:0] !== 16'd1) begin n_err++; $display("FAIL rmid_pre_acc: got %0d expected 1", if_a.acc[15:0]); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (if_a.acc !== 64'd0) begin n_err++; $display("FAIL rmid_acc: got %h expected 0", if_a.acc); end
    n_vec++; if (if_a.dist_valid !== 4'd0) begin n_err++; $display("FAIL rmid_dv: got %b expected 0", if_a.dist_valid); end
    n_vec++; if (if_a.sat !== 4'd0) begin n_err++; $display("FAIL rmid_sat: got %b expected 0", if_a.sat); end
    n_vec++; if (if_a.r_out !== 8'd0) begin n_err++; $display("FAIL rmid_rout: got %0d expected 0", if_a.r_out); end
    n_vec++; if (if_b.acc !== 10'd0) begin n_err++; $display("FAIL rmid_acc_b: got %0d expected 0", if_b.acc); end
    drive(8'd0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    drive(8'd3, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(8'd4, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
    for (int k = 0; k < 6; k++) begin
      idle(1);
      if (k == 0) begin
        n_vec++; if (if_a.acc[15:0] !== 16'd7) begin n_err++; $display("FAIL rmid_orphan_acc: got %0d expected 7", if_a.acc[15:0]); end
      end
      n_vec++; if (if_a.dist_valid !== 4'd0) begin n_err++; $display("FAIL rmid_orphan_dv k=%0d: got %b expected 0", k, if_a.dist_valid); end
    end
    drive(8'd5, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
    drive(8'd5, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
    idle(1);
    n_vec++; if (if_a.dist_valid[0] !== 1'b1) begin n_err++; $display("FAIL rmid_new_dv: got %b expected 1", if_a.dist_valid[0]); end
    n_vec++; if (if_a.acc[15:0] !== 16'd10) begin n_err++; $display("FAIL rmid_new_acc: got %0d expected 10", if_a.acc[15:0]); end
    idle(6);
  endtask

  // sequence and report
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_large();
    test_saturation();
    test_skew();
    test_bubbles();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
